// File: rtl/dense_sr_ctrl_if.sv
// dense_sr_ctrl_if
//   Bundles the handshake and status signals of the dense shift-register
//   window controller.
//   master : upstream/downstream side (drives start, in_valid, win_ready)
//   slave  : the controller itself (drives in_ready, shift_en, window
//            outputs, busy, done)
//   win_row/win_col widths follow the image geometry parameters.
interface dense_sr_ctrl_if #(
   parameter int IMG_WIDTH  = 8,
   parameter int IMG_HEIGHT = 8
);
   logic                          start;
   logic                          in_valid;
   logic                          in_ready;
   logic                          shift_en;
   logic                          win_valid;
   logic                          win_ready;
   logic [$clog2(IMG_HEIGHT)-1:0] win_row;
   logic [$clog2(IMG_WIDTH)-1:0]  win_col;
   logic                          busy;
   logic                          done;

   modport master (
      output start, in_valid, win_ready,
      input  in_ready, shift_en, win_valid, win_row, win_col, busy, done
   );

   modport slave (
      input  start, in_valid, win_ready,
      output in_ready, shift_en, win_valid, win_row, win_col, busy, done
   );
endinterface

// File: rtl/dense_sr_ctrl.sv
// dense_sr_ctrl
//   Controls a dense shift-register window buffer fed in raster order.
//   It accepts one pixel per shift_en strobe, tracks the (row, col) of the
//   incoming pixel and flags when the shift chain holds a complete,
//   non-straddling P_SR_DEPTH x NUM_SR_ROWS window, reporting its top-left
//   corner. A frame runs IDLE -> FILL -> RUN -> DRAIN -> DONE -> IDLE.
//   Ports:
//     clock : single clock, rising edge
//     reset : asynchronous, active-low
//     bus   : dense_sr_ctrl_if slave modport
//             start (in), in_valid (in), in_ready (out), shift_en (out),
//             win_valid (out), win_ready (in), win_row/win_col (out),
//             busy (out), done (out)
module dense_sr_ctrl #(
   parameter int IMG_WIDTH   = 8,
   parameter int IMG_HEIGHT  = 8,
   parameter int P_SR_DEPTH  = 3,
   parameter int NUM_SR_ROWS = 3
) (
   input  logic           clock,
   input  logic           reset,
   dense_sr_ctrl_if.slave bus
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   // First pixel position at which the chain holds a full window.
   localparam logic [CW-1:0] COL_WIN0 = CW'(P_SR_DEPTH - 1);
   localparam logic [RW-1:0] ROW_WIN0 = RW'(NUM_SR_ROWS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          win_valid_q, win_valid_d;
   logic [RW-1:0] win_row_q, win_row_d;
   logic [CW-1:0] win_col_q, win_col_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic in_ready;
   logic accept;
   logic win_take;
   logic window_hit;
   logic last_pix;

   always_comb begin
      // Stall intake while a window is waiting and downstream is not taking
      // it; otherwise the window it would overwrite is lost.
      in_ready   = ((state_q == ST_FILL) || (state_q == ST_RUN)) &&
                   !(win_valid_q && !bus.win_ready);
      accept     = bus.in_valid && in_ready;
      win_take   = win_valid_q && bus.win_ready;
      // Column test also rejects windows straddling a row boundary.
      window_hit = accept && (row_q >= ROW_WIN0) && (col_q >= COL_WIN0);
      last_pix   = accept && (row_q == ROW_LAST) && (col_q == COL_LAST);

      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      win_valid_d = win_valid_q;
      win_row_d   = win_row_q;
      win_col_d   = win_col_q;

      if (win_take) begin
         win_valid_d = 1'b0;
      end
      // A new window loaded in the same cycle replaces the consumed one.
      if (window_hit) begin
         win_valid_d = 1'b1;
         win_row_d   = row_q - ROW_WIN0;
         win_col_d   = col_q - COL_WIN0;
      end

      if (accept) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_FILL;
               col_d   = '0;
               row_d   = '0;
            end
         end
         ST_FILL: begin
            if (last_pix) begin
               state_d = ST_DRAIN;
            end else if (window_hit) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_pix) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!win_valid_q || bus.win_ready) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status outputs are registered from the next state so they line up
      // with the state register.
      busy_d = (state_d == ST_FILL) || (state_d == ST_RUN) ||
               (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         win_valid_q <= 1'b0;
         win_row_q   <= '0;
         win_col_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         win_valid_q <= win_valid_d;
         win_row_q   <= win_row_d;
         win_col_q   <= win_col_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.shift_en  = accept;
   assign bus.win_valid = win_valid_q;
   assign bus.win_row   = win_row_q;
   assign bus.win_col   = win_col_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_dense_sr_ctrl.sv
// tb_dense_sr_ctrl
//   Scoreboard bench for dense_sr_ctrl on a 4x4 image with a 3x3 window.
//   Stimulus pushes the expected windows (row, col, accepts seen so far)
//   into a queue; a monitor pops and compares on every window handshake.
module tb_dense_sr_ctrl;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int PD = 3;
   localparam int NR = 3;

   logic clock = 1'b0;
   logic reset = 1'b0;

   dense_sr_ctrl_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

   dense_sr_ctrl #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .P_SR_DEPTH (PD),
      .NUM_SR_ROWS(NR)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      int row;
      int col;
      int acc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   errors   = 0;
   int   acc_cnt  = 0;
   int   done_cnt = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: windows are compared on the handshake, before this cycle's
   // accept is counted, so acc equals the number of pixels already shifted.
   always @(negedge clock) begin
      if (reset) begin
         if (bus.shift_en) begin
            check("shift_needs_valid", int'(bus.in_valid), 1);
         end
         if (bus.win_valid && bus.win_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_window actual=(%0d,%0d) required=none",
                        bus.win_row, bus.win_col);
            end else begin
               mon_e = exp_q.pop_front();
               $display("WIN row=%0d col=%0d after %0d accepts (exp %0d,%0d @%0d)",
                        bus.win_row, bus.win_col, acc_cnt,
                        mon_e.row, mon_e.col, mon_e.acc);
               check("win_row", int'(bus.win_row), mon_e.row);
               check("win_col", int'(bus.win_col), mon_e.col);
               check("win_accepts", acc_cnt, mon_e.acc);
            end
         end
         if (bus.shift_en) acc_cnt++;
         if (bus.done) done_cnt++;
      end
   end

   // Windows of a 4x4 frame with a 3x3 window: accepts 10,11,14,15
   // (zero-based) produce (0,0),(0,1),(1,0),(1,1).
   task automatic push_windows(input int n);
      int rows[4] = '{0, 0, 1, 1};
      int cols[4] = '{0, 1, 0, 1};
      int accs[4] = '{11, 12, 15, 16};
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.row = rows[i];
         e.col = cols[i];
         e.acc = accs[i];
         exp_q.push_back(e);
      end
   endtask

   task automatic start_frame(input bit hold_start);
      acc_cnt    = 0;
      done_cnt   = 0;
      bus.start  = 1'b1;
      @(posedge clock); #1;
      bus.start  = hold_start;
   endtask

   task automatic wait_done(input string name, input bit toggle);
      for (int i = 0; i < 300; i++) begin
         if (done_cnt != 0) break;
         if (toggle) bus.in_valid = ~bus.in_valid;
         @(posedge clock); #1;
      end
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check({name, "_done_pulses"}, done_cnt, 1);
      check({name, "_accepts"}, acc_cnt, 16);
      check({name, "_windows_left"}, exp_q.size(), 0);
      check({name, "_busy_idle"}, int'(bus.busy), 0);
      check({name, "_in_ready_idle"}, int'(bus.in_ready), 0);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_in_ready"}, int'(bus.in_ready), 0);
      check({name, "_shift_en"}, int'(bus.shift_en), 0);
      check({name, "_win_valid"}, int'(bus.win_valid), 0);
      check({name, "_win_row"}, int'(bus.win_row), 0);
      check({name, "_win_col"}, int'(bus.win_col), 0);
      check({name, "_busy"}, int'(bus.busy), 0);
      check({name, "_done"}, int'(bus.done), 0);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.win_ready = 1'b1;
      #1;
      check_reset_outputs("por");
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      check("idle_busy", int'(bus.busy), 0);

      // Continuous streaming.
      bus.in_valid  = 1'b1;
      bus.win_ready = 1'b1;
      push_windows(4);
      start_frame(1'b0);
      wait_done("stream", 1'b0);

      // Downstream stalls on the first window.
      bus.win_ready = 1'b0;
      push_windows(4);
      start_frame(1'b0);
      for (int i = 0; i < 100; i++) begin
         if (bus.win_valid) break;
         @(posedge clock); #1;
      end
      for (int i = 0; i < 4; i++) begin
         check("stall_win_valid", int'(bus.win_valid), 1);
         check("stall_win_row", int'(bus.win_row), 0);
         check("stall_win_col", int'(bus.win_col), 0);
         check("stall_in_ready", int'(bus.in_ready), 0);
         check("stall_shift_en", int'(bus.shift_en), 0);
         check("stall_accepts", acc_cnt, 11);
         @(posedge clock); #1;
      end
      bus.win_ready = 1'b1;
      wait_done("stall", 1'b0);

      // in_valid toggling every cycle.
      push_windows(4);
      start_frame(1'b0);
      wait_done("gaps", 1'b1);

      // start held high through the whole frame.
      push_windows(4);
      start_frame(1'b1);
      wait_done("start_in_run", 1'b0);

      // Reset after accept 12.
      push_windows(2);
      start_frame(1'b0);
      for (int i = 0; i < 100; i++) begin
         if (acc_cnt >= 13) break;
         @(posedge clock); #1;
      end
      check("rst_accepts_before", acc_cnt, 13);
      reset = 1'b0;
      #1;
      check_reset_outputs("midrst");
      check("midrst_windows_left", exp_q.size(), 0);
      repeat (2) @(posedge clock);
      #1;
      check("midrst_no_done", done_cnt, 0);
      check("midrst_busy", int'(bus.busy), 0);
      reset = 1'b1;
      @(posedge clock); #1;
      check("midrst_stays_idle", int'(bus.busy), 0);
      push_windows(4);
      start_frame(1'b0);
      wait_done("after_rst", 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
